vec_dispatch_queue: RTL and testbench

Sits between the scalar core's decode stage and the vector processor inside system_top. Buffers forwarded vector instructions and their rs1/rs2 operands in a small FIFO, then issues them one at a time to the vector processor using a valid/ready handshake. Tracks completion acks and returns scalar results of vset* instructions to the scalar core. Raises back-pressure so the scalar core stalls only when the queue is full or a scalar-result instruction is outstanding.

---
 rtl/vec_dispatch_pkg.sv | 26 ++
 rtl/vec_dispatch_fifo.sv | 59 +++++
 rtl/vec_dispatch_queue.sv | 178 +++++++++++++++++
 tb/tb_vec_dispatch_queue.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_dispatch_pkg.sv
// Shared types and decode constants for the vector dispatch queue.
package vec_dispatch_pkg;

    // OP-V major opcode and the OPCFG funct3 used by vsetvli/vsetivli/vsetvl.
    localparam logic [6:0] OPC_OP_V = 7'b1010111;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    // Default-width queue entry. The top level re-declares this shape with its own widths.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        sync;
    } dispatch_entry_t;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } disp_state_e;

    // vset* instructions return a new vl to the scalar core, so they must serialize.
    function automatic logic is_sync_inst(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_OP_V) && (funct3 == F3_OPCFG);
    endfunction

endpackage

// File: rtl/vec_dispatch_fifo.sv
// Synchronous FIFO of dispatch entries. Push when full and pop when empty are ignored.
module vec_dispatch_fifo
    import vec_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = dispatch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/vec_dispatch_queue.sv
// Vector dispatch queue: buffers scalar-forwarded vector instructions, issues them one at a
// time to the vector unit, tracks acks and returns vset* results.
// Optional macro VEC_DISPATCH_BYPASS_EN: zero-latency s_* -> v_* path when queue is empty.
module vec_dispatch_queue
    import vec_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INST_W = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [INST_W-1:0] s_inst,
    input  logic [XLEN-1:0]   s_rs1,
    input  logic [XLEN-1:0]   s_rs2,
    output logic              s_ready,
    output logic              v_valid,
    output logic [INST_W-1:0] v_inst,
    output logic [XLEN-1:0]   v_rs1,
    output logic [XLEN-1:0]   v_rs2,
    input  logic              v_ready,
    input  logic              v_ack,
    input  logic              v_error,
    input  logic [XLEN-1:0]   v_csr_out,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic              busy,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  error_cnt
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic              sync;
    } entry_t;

    localparam int unsigned CNTF_W = $clog2(DEPTH) + 1;

    disp_state_e       state_q, state_d;
    logic              sync_q, sync_d;
    logic              sync_pending_q, sync_pending_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0]  error_cnt_q, error_cnt_d;

    entry_t            in_entry;
    entry_t            head;
    entry_t            issue_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNTF_W-1:0] fifo_count;
    logic              enq;
    logic              offer;
    logic              fire;

    assign in_entry = '{inst: s_inst, rs1: s_rs1, rs2: s_rs2,
                        sync: is_sync_inst(s_inst[6:0], s_inst[14:12])};

    // Full is the registered count, so a same-cycle pop never frees a slot early.
    assign s_ready = !rst && !fifo_full && !sync_pending_q;
    assign enq     = s_valid && s_ready;

`ifdef VEC_DISPATCH_BYPASS_EN
    logic bypass;
    assign bypass      = fifo_empty && (state_q == IDLE) && enq;
    assign issue_entry = fifo_empty ? in_entry : head;
    assign offer       = (state_q == IDLE) && (!fifo_empty || bypass);
    // A bypassed entry accepted immediately never touches the FIFO.
    assign fifo_push   = enq && !(bypass && v_ready);
    assign fifo_pop    = fire && !fifo_empty;
`else
    assign issue_entry = head;
    assign offer       = (state_q == IDLE) && !fifo_empty;
    assign fifo_push   = enq;
    assign fifo_pop    = fire;
`endif

    assign fire    = offer && v_ready;
    assign v_valid = offer;
    assign v_inst  = offer ? issue_entry.inst : '0;
    assign v_rs1   = offer ? issue_entry.rs1  : '0;
    assign v_rs2   = offer ? issue_entry.rs2  : '0;

    vec_dispatch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue FSM next state, sync tracking, writeback and saturating counters.
    always_comb begin
        state_d        = state_q;
        sync_d         = sync_q;
        sync_pending_d = sync_pending_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        err_sticky_d   = err_sticky_q;
        issued_cnt_d   = issued_cnt_q;
        error_cnt_d    = error_cnt_q;
        if (enq && in_entry.sync) begin
            sync_pending_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = WAIT_ACK;
                    sync_d  = issue_entry.sync;
                    if (issued_cnt_q != '1) issued_cnt_d = issued_cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (v_ack) begin
                    state_d = IDLE;
                    if (v_error) begin
                        err_sticky_d = 1'b1;
                        if (error_cnt_q != '1) error_cnt_d = error_cnt_q + CNT_W'(1);
                    end
                    // Errored sync acks still return the result; the core must not hang.
                    if (sync_q) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = v_csr_out;
                        sync_pending_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops every queued and in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sync_q         <= 1'b0;
            sync_pending_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            err_sticky_q   <= 1'b0;
            issued_cnt_q   <= '0;
            error_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            sync_pending_q <= sync_pending_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            err_sticky_q   <= err_sticky_d;
            issued_cnt_q   <= issued_cnt_d;
            error_cnt_q    <= error_cnt_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign err_sticky = err_sticky_q;
    assign issued_cnt = issued_cnt_q;
    assign error_cnt  = error_cnt_q;
    assign busy       = (fifo_count != '0) || (state_q == WAIT_ACK);

endmodule

// File: tb/tb_vec_dispatch_queue.sv
// Directed self-checking bench for vec_dispatch_queue (default build, no bypass).
module tb_vec_dispatch_queue;

    localparam logic [31:0] VADD = 32'h022180D7;
    localparam logic [31:0] VSET = 32'h010572D7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_inst = '0, s_rs1 = '0, s_rs2 = '0;
    logic        s_ready;
    logic        v_valid;
    logic [31:0] v_inst, v_rs1, v_rs2;
    logic        v_ready = 1'b0, v_ack = 1'b0, v_error = 1'b0;
    logic [31:0] v_csr_out = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        busy, err_sticky;
    logic [15:0] issued_cnt, error_cnt;

    int checks = 0;
    int errors = 0;

    vec_dispatch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_inst     (s_inst),
        .s_rs1      (s_rs1),
        .s_rs2      (s_rs2),
        .s_ready    (s_ready),
        .v_valid    (v_valid),
        .v_inst     (v_inst),
        .v_rs1      (v_rs1),
        .v_rs2      (v_rs2),
        .v_ready    (v_ready),
        .v_ack      (v_ack),
        .v_error    (v_error),
        .v_csr_out  (v_csr_out),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .busy       (busy),
        .err_sticky (err_sticky),
        .issued_cnt (issued_cnt),
        .error_cnt  (error_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_valid = 0; v_ready = 0; v_ack = 0; v_error = 0; v_csr_out = 0;
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        #1;
    endtask

    // Push one instruction, let it issue, ack it the cycle after issue.
    task automatic issue_one(input logic [31:0] inst, input logic err, input logic [31:0] csr);
        s_valid = 1; s_inst = inst; v_ready = 1;
        cyc();
        s_valid = 0;
        cyc();
        v_ack = 1; v_error = err; v_csr_out = csr;
        cyc();
        v_ack = 0; v_error = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        cyc(); cyc(); cyc();
        checks++;
        if ({s_ready, v_valid, wb_valid, busy, err_sticky} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {s_ready, v_valid, wb_valid, busy, err_sticky});
        end
        checks++;
        if ({v_inst, v_rs1, v_rs2, wb_data, issued_cnt, error_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: outputs nonzero during reset");
        end
        rst = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || issued_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b busy=%b issued=%0d want 1 0 0",
                     s_ready, busy, issued_cnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        s_valid = 1; s_inst = VADD; s_rs1 = 32'h11; s_rs2 = 32'h22; v_ready = 1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || v_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: s_ready=%b v_valid=%b want 1 0", s_ready, v_valid);
        end
        cyc();
        s_valid = 0;
        #1;
        checks++;
        if (v_valid !== 1'b1 || v_inst !== VADD || v_rs1 !== 32'h11 || v_rs2 !== 32'h22) begin
            errors++;
            $display("FAIL single_payload: v_valid=%b inst=%h rs1=%h rs2=%h want 1 %h 11 22",
                     v_valid, v_inst, v_rs1, v_rs2, VADD);
        end
        cyc();
        checks++;
        if (v_valid !== 1'b0 || busy !== 1'b1 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_issued: v_valid=%b busy=%b issued=%0d want 0 1 1",
                     v_valid, busy, issued_cnt);
        end
        cyc(); cyc();
        v_ack = 1;
        cyc();
        v_ack = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_ack: busy=%b wb_valid=%b issued=%0d want 0 0 1",
                     busy, wb_valid, issued_cnt);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] insts [5];
        for (int k = 0; k < 5; k++) insts[k] = VADD + (32'(k) << 7);
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1; s_inst = insts[k];
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept%0d: s_ready=%b want 1", k, s_ready);
            end
            cyc();
        end
        s_inst = insts[4];
        #1;
        checks++;
        if (s_ready !== 1'b0 || v_valid !== 1'b1 || v_inst !== insts[0]) begin
            errors++;
            $display("FAIL bp_full: s_ready=%b v_valid=%b inst=%h want 0 1 %h",
                     s_ready, v_valid, v_inst, insts[0]);
        end
        cyc();
        checks++;
        if (v_valid !== 1'b1 || v_inst !== insts[0] || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable: v_valid=%b inst=%h s_ready=%b want 1 %h 0",
                     v_valid, v_inst, s_ready, insts[0]);
        end
        v_ready = 1;
        cyc();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_space: s_ready=%b want 1", s_ready);
        end
        cyc();
        s_valid = 0;
        v_ack = 1;
        cyc();
        v_ack = 0;
        for (int k = 1; k < 5; k++) begin
            #1;
            checks++;
            if (v_valid !== 1'b1 || v_inst !== insts[k]) begin
                errors++;
                $display("FAIL bp_order%0d: v_valid=%b inst=%h want 1 %h",
                         k, v_valid, v_inst, insts[k]);
            end
            cyc();
            cyc();
            v_ack = 1;
            cyc();
            v_ack = 0;
        end
        #1;
        checks++;
        if (issued_cnt !== 16'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: issued=%0d busy=%b want 5 0", issued_cnt, busy);
        end
    endtask

    task automatic test_sync_stall();
        apply_reset();
        v_ready = 1;
        s_valid = 1; s_inst = VSET; s_rs1 = 32'd8; s_rs2 = 32'd0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sync_accept: s_ready=%b want 1", s_ready);
        end
        cyc();
        s_inst = VADD; s_rs1 = 32'h1;
        #1;
        checks++;
        if (s_ready !== 1'b0 || v_valid !== 1'b1 || v_inst !== VSET || v_rs1 !== 32'd8) begin
            errors++;
            $display("FAIL sync_block: s_ready=%b v_valid=%b inst=%h rs1=%h want 0 1 %h 8",
                     s_ready, v_valid, v_inst, v_rs1, VSET);
        end
        cyc();
        checks++;
        if (s_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_wait: s_ready=%b wb_valid=%b want 0 0", s_ready, wb_valid);
        end
        v_ack = 1; v_csr_out = 32'd8;
        cyc();
        v_ack = 0;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd8 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sync_wb: wb_valid=%b wb_data=%0d s_ready=%b want 1 8 1",
                     wb_valid, wb_data, s_ready);
        end
        cyc();
        s_valid = 0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || v_valid !== 1'b1 || v_inst !== VADD) begin
            errors++;
            $display("FAIL sync_next: wb_valid=%b v_valid=%b inst=%h want 0 1 %h",
                     wb_valid, v_valid, v_inst, VADD);
        end
    endtask

    task automatic test_error();
        apply_reset();
        issue_one(VADD, 1'b1, 32'h0);
        checks++;
        if (err_sticky !== 1'b1 || error_cnt !== 16'd1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_first: sticky=%b cnt=%0d wb=%b want 1 1 0",
                     err_sticky, error_cnt, wb_valid);
        end
        issue_one(VADD, 1'b1, 32'h0);
        checks++;
        if (err_sticky !== 1'b1 || error_cnt !== 16'd2) begin
            errors++;
            $display("FAIL err_second: sticky=%b cnt=%0d want 1 2", err_sticky, error_cnt);
        end
        v_ack = 1; v_error = 1; v_csr_out = 32'h77;
        cyc();
        v_ack = 0; v_error = 0;
        #1;
        checks++;
        if (error_cnt !== 16'd2 || issued_cnt !== 16'd2 || wb_valid !== 1'b0 || busy !== 1'b0)
        begin
            errors++;
            $display("FAIL err_spurious: cnt=%0d issued=%0d wb=%b busy=%b want 2 2 0 0",
                     error_cnt, issued_cnt, wb_valid, busy);
        end
        issue_one(VSET, 1'b1, 32'h5);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h5 || error_cnt !== 16'd3) begin
            errors++;
            $display("FAIL err_sync: wb=%b data=%h cnt=%0d want 1 5 3",
                     wb_valid, wb_data, error_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1; s_inst = VADD + (32'(k) << 7);
            cyc();
        end
        s_valid = 0;
        v_ready = 1;
        cyc();
        v_ready = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || issued_cnt !== 16'd1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_loaded: busy=%b issued=%0d s_ready=%b want 1 1 1",
                     busy, issued_cnt, s_ready);
        end
        rst = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || issued_cnt !== 16'd0 || v_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b issued=%0d v_valid=%b want 0 0 0",
                     busy, issued_cnt, v_valid);
        end
        cyc();
        rst = 0;
        v_ack = 1; v_error = 1;
        cyc();
        v_ack = 0; v_error = 0;
        #1;
        checks++;
        if (err_sticky !== 1'b0 || error_cnt !== 16'd0 || busy !== 1'b0 || wb_valid !== 1'b0
            || v_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_ack: sticky=%b cnt=%0d busy=%b wb=%b v_valid=%b want 0",
                     err_sticky, error_cnt, busy, wb_valid, v_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_sync_stall();
        test_error();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
